// File: rtl/dk_video_pkg.sv
// Shared raster defaults and the per-pixel fetch phase handed from timing to the fetch datapath.
package dk_video_pkg;
  localparam int CNT_W = 9;

  localparam int DEF_H_ACTIVE     = 128;
  localparam int DEF_H_SYNC_START = 136;
  localparam int DEF_H_SYNC_END   = 148;
  localparam int DEF_H_TOTAL      = 160;
  localparam int DEF_V_ACTIVE     = 128;
  localparam int DEF_V_SYNC_START = 200;
  localparam int DEF_V_SYNC_END   = 203;
  localparam int DEF_V_TOTAL      = 262;

  localparam int DEF_BYTES_PER_LINE = DEF_H_ACTIVE / 8;

  typedef struct packed {
    logic             issue;   // issue a byte read at this h
    logic             load;    // shift register takes q_b at this h
    logic             active;  // (h,v) is inside the visible area
    logic [CNT_W-1:0] col;     // column byte of the read being issued
    logic [CNT_W-1:0] row;     // target line of the read being issued
  } fetch_phase_t;
endpackage

// File: rtl/dk_video_timing.sv
// Raster counters, registered blank/sync outputs and the combinational fetch-phase decode.
module dk_video_timing import dk_video_pkg::*; #(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END,
  parameter int V_TOTAL      = DEF_V_TOTAL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce_pix,
  output fetch_phase_t     phase,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);
  localparam logic [CNT_W-1:0] HA    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HA_M1 = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HA_M2 = CNT_W'(H_ACTIVE - 2);
  localparam logic [CNT_W-1:0] HSS   = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] HSE   = CNT_W'(H_SYNC_END);
  localparam logic [CNT_W-1:0] HT_M1 = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HT_M2 = CNT_W'(H_TOTAL - 2);
  localparam logic [CNT_W-1:0] VA    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VSS   = CNT_W'(V_SYNC_START);
  localparam logic [CNT_W-1:0] VSE   = CNT_W'(V_SYNC_END);
  localparam logic [CNT_W-1:0] VT_M1 = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h, v;
  logic             h_wrap, v_wrap, line_fetch;

  assign h_wrap     = (h == HT_M1);
  assign v_wrap     = (v == VT_M1);
  assign line_fetch = (h == HT_M2);

  // Column 0 of each line is fetched two pixels before the line starts, i.e. at the
  // tail of the previous line, so its target row is one ahead of v.
  always_comb begin
    phase        = '0;
    phase.issue  = line_fetch || (h[2:0] == 3'd6 && h < HA_M2);
    phase.load   = h_wrap || (h[2:0] == 3'd7 && h < HA_M1);
    phase.active = (h < HA) && (v < VA);
    phase.col    = line_fetch ? '0 : (h + CNT_W'(2)) >> 3;
    phase.row    = line_fetch ? (v_wrap ? '0 : v + CNT_W'(1)) : v;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h      <= '0;
      v      <= '0;
      h_cnt  <= '0;
      v_cnt  <= '0;
      hblank <= 1'b0;
      vblank <= 1'b0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else if (ce_pix) begin
      h <= h_wrap ? '0 : h + CNT_W'(1);
      if (h_wrap) v <= v_wrap ? '0 : v + CNT_W'(1);
      h_cnt  <= h;
      v_cnt  <= v;
      hblank <= (h >= HA);
      vblank <= (v >= VA);
      hsync  <= (h >= HSS) && (h < HSE);
      vsync  <= (v >= VSS) && (v < VSE);
    end
  end
endmodule

// File: rtl/dk_video_fetch.sv
// Framebuffer port-B scanout: byte-read address/strobe generation and 1bpp MSB-first serialiser.
module dk_video_fetch import dk_video_pkg::*; #(
  parameter int ADDR_WIDTH   = 11,
  parameter int BASE_ADDR    = 0,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END,
  parameter int V_TOTAL      = DEF_V_TOTAL
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ce_pix,
  output logic [ADDR_WIDTH-1:0] address_b,
  output logic                  enable_b,
  input  logic [7:0]            q_b,
  output logic                  pix,
  output logic                  hblank,
  output logic                  vblank,
  output logic                  hsync,
  output logic                  vsync,
  output logic [CNT_W-1:0]      h_cnt,
  output logic [CNT_W-1:0]      v_cnt
);
  localparam int               BPL = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] VA  = CNT_W'(V_ACTIVE);

  fetch_phase_t phase;
  logic [7:0]   sh;

  dk_video_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .H_SYNC_START(H_SYNC_START),
    .H_SYNC_END  (H_SYNC_END),
    .H_TOTAL     (H_TOTAL),
    .V_ACTIVE    (V_ACTIVE),
    .V_SYNC_START(V_SYNC_START),
    .V_SYNC_END  (V_SYNC_END),
    .V_TOTAL     (V_TOTAL)
  ) u_timing (
    .clock (clock),
    .reset (reset),
    .ce_pix(ce_pix),
    .phase (phase),
    .hblank(hblank),
    .vblank(vblank),
    .hsync (hsync),
    .vsync (vsync),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt)
  );

  // q_b is consumed one ce_pix after the strobe; ce_pix spacing leaves the RAM a clock to answer.
  always_ff @(posedge clock) begin
    if (reset) begin
      address_b <= '0;
      enable_b  <= 1'b0;
      sh        <= '0;
      pix       <= 1'b0;
    end else begin
      enable_b <= 1'b0;
      if (ce_pix) begin
        if (phase.issue && phase.row < VA) begin
          enable_b  <= 1'b1;
          address_b <= ADDR_WIDTH'(32'(BASE_ADDR) + 32'(phase.row) * 32'(BPL) + 32'(phase.col));
        end
        pix <= phase.active & sh[7];
        if (phase.load)        sh <= q_b;
        else if (phase.active) sh <= {sh[6:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_dk_video_fetch.sv
// Randomised bench for dk_video_fetch on a reduced raster, checked against a frame-level model.
`timescale 1ns/1ps
module tb_dk_video_fetch;
  localparam int AW   = 7;
  localparam int BASE = 60;
  localparam int HA   = 32, HSS = 36, HSE = 42, HT = 44;
  localparam int VA   = 20, VSS = 22, VSE = 24, VT = 26;
  localparam int BPL  = HA / 8;
  localparam int MEMN = 1 << AW;
  localparam int FRAME = HT * VT;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ce_pix = 1'b0;
  logic [AW-1:0] address_b;
  logic          enable_b;
  logic [7:0]    q_b = 8'h00;
  logic          pix, hblank, vblank, hsync, vsync;
  logic [8:0]    h_cnt, v_cnt;

  dk_video_fetch #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .clock(clock), .reset(reset), .ce_pix(ce_pix),
    .address_b(address_b), .enable_b(enable_b), .q_b(q_b),
    .pix(pix), .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .h_cnt(h_cnt), .v_cnt(v_cnt)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [MEMN];
  always @(posedge clock) if (enable_b) q_b <= mem[address_b];

  // ce_mode 0: random gaps of 1..3 low clocks; N>0: fixed N low clocks between pulses
  int ce_mode = 1;
  int ce_cnt  = 0;
  always begin
    @(posedge clock);
    #1;
    if (ce_cnt == 0) begin
      ce_pix = 1'b1;
      ce_cnt = (ce_mode == 0) ? int'($urandom_range(1, 3)) : ce_mode;
    end else begin
      ce_pix = 1'b0;
      ce_cnt--;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int nh = 0, nv = 0;
  bit blank0 = 1'b1;
  bit last_ce;
  logic [8:0]    e_h, e_v;
  logic [AW-1:0] e_addr;
  bit e_pix, e_hb, e_vb, e_hs, e_vs, e_en;

  function automatic bit issue_at(int h, int v, output int addr);
    int r;
    addr = 0;
    for (int k = 0; k < BPL; k++) begin
      if (h == (8 * k - 2 + HT) % HT) begin
        r = (k == 0) ? (v + 1) % VT : v;
        if (r < VA) begin
          addr = (BASE + r * BPL + k) % MEMN;
          return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic bit pix_at(int h, int v);
    logic [7:0] b;
    if (h >= HA || v >= VA) return 1'b0;
    if (blank0 && v == 0 && h < 8) return 1'b0;
    b = mem[(BASE + v * BPL + h / 8) % MEMN];
    return b[7 - h % 8];
  endfunction

  // One clock: sample what the DUT saw at the edge, then advance the model to match.
  task automatic tick();
    bit c, r;
    int a;
    @(posedge clock);
    c = ce_pix;
    r = reset;
    #2;
    last_ce = c;
    if (r) begin
      nh = 0; nv = 0; blank0 = 1'b1;
      e_h = '0; e_v = '0; e_addr = '0;
      {e_pix, e_hb, e_vb, e_hs, e_vs, e_en} = '0;
    end else begin
      e_en = 1'b0;
      if (c) begin
        e_en = issue_at(nh, nv, a);
        if (e_en) e_addr = AW'(a);
        e_h   = 9'(nh);
        e_v   = 9'(nv);
        e_pix = pix_at(nh, nv);
        e_hb  = (nh >= HA);
        e_vb  = (nv >= VA);
        e_hs  = (nh >= HSS && nh < HSE);
        e_vs  = (nv >= VSS && nv < VSE);
        if (nh == HT - 2 && nv == VT - 1) blank0 = 1'b0;
        nh++;
        if (nh == HT) begin
          nh = 0;
          nv = (nv + 1) % VT;
        end
      end
    end
  endtask

  task automatic goto_pos(int tv, int th);
    for (int i = 0; i < 20000 && !(nv == tv && nh == th); i++) tick();
  endtask

  task automatic test_reset();
    ce_mode = 1;
    for (int i = 0; i < MEMN; i++) mem[i] = 8'($urandom);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({pix, hblank, vblank, hsync, vsync, enable_b} !== 6'b0 ||
          address_b !== '0 || h_cnt !== '0 || v_cnt !== '0) begin
        n_bad++;
        $display("FAIL reset_state cyc=%0d got pix%b hb%b vb%b hs%b vs%b en%b a=%0d h=%0d v=%0d want all 0",
                 i, pix, hblank, vblank, hsync, vsync, enable_b, address_b, h_cnt, v_cnt);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_raster();
    ce_mode = 3;
    for (int i = 0; i < FRAME * 4 + 40; i++) begin
      tick();
      n_cmp++;
      if (h_cnt !== e_h || v_cnt !== e_v) begin
        n_bad++;
        $display("FAIL raster_cnt got h=%0d v=%0d want h=%0d v=%0d", h_cnt, v_cnt, e_h, e_v);
      end
      n_cmp++;
      if ({hblank, vblank, hsync, vsync} !== {e_hb, e_vb, e_hs, e_vs}) begin
        n_bad++;
        $display("FAIL raster_sync h=%0d v=%0d got hb%b vb%b hs%b vs%b want hb%b vb%b hs%b vs%b",
                 e_h, e_v, hblank, vblank, hsync, vsync, e_hb, e_vb, e_hs, e_vs);
      end
    end
  endtask

  task automatic test_fetch();
    ce_mode = 0;
    for (int i = 0; i < FRAME * 3 + 60; i++) begin
      tick();
      n_cmp++;
      if (enable_b !== e_en) begin
        n_bad++;
        $display("FAIL fetch_strobe h=%0d v=%0d ce=%b got %b want %b", e_h, e_v, last_ce, enable_b, e_en);
      end
      n_cmp++;
      if (address_b !== e_addr) begin
        n_bad++;
        $display("FAIL fetch_addr h=%0d v=%0d got %0d want %0d", e_h, e_v, address_b, e_addr);
      end
    end
  endtask

  task automatic test_pixels(int mode);
    int nce = 0;
    goto_pos(VA + 1, 0);
    for (int i = 0; i < MEMN; i++) mem[i] = 8'($urandom);
    ce_mode = mode;
    while (nce < 2 * FRAME) begin
      tick();
      if (last_ce) nce++;
      n_cmp++;
      if (pix !== e_pix) begin
        n_bad++;
        $display("FAIL pixel mode=%0d h=%0d v=%0d got %b want %b", mode, e_h, e_v, pix, e_pix);
      end
    end
  endtask

  task automatic test_mid_reset();
    int nce = 0;
    ce_mode = 0;
    goto_pos(VA / 2, HT / 2 + 3);
    mem[BASE % MEMN] = 8'hFF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (h_cnt !== '0 || v_cnt !== '0 || pix !== 1'b0 || enable_b !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_state got h=%0d v=%0d pix=%b en=%b want 0 0 0 0", h_cnt, v_cnt, pix, enable_b);
    end
    while (nce < FRAME + HT) begin
      tick();
      if (last_ce) nce++;
      n_cmp++;
      if (pix !== e_pix || h_cnt !== e_h || v_cnt !== e_v) begin
        n_bad++;
        $display("FAIL mid_reset_pix got h=%0d v=%0d pix=%b want h=%0d v=%0d pix=%b",
                 h_cnt, v_cnt, pix, e_h, e_v, e_pix);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_fetch();
    test_pixels(1);
    test_pixels(0);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
